// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch controller slice: time/prescaler
// widths, the FSM state type and an mm:ss record.
package stopwatch_pkg;

  localparam int TIME_W = 6;
  localparam int DIV_W  = 8;

  localparam logic [TIME_W-1:0] SEC_MAX = 6'd59;
  localparam logic [TIME_W-1:0] MIN_MAX = 6'd59;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE,
    DONE  = ST_DONE
  } state_e;

  typedef struct packed {
    logic [TIME_W-1:0] min;
    logic [TIME_W-1:0] sec;
  } mmss_t;

  // An alarm time outside 00:00..59:59 can never be reached by the counter.
  function automatic logic time_valid(mmss_t t);
    return (t.min <= MIN_MAX) && (t.sec <= SEC_MAX);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Command, configuration and status bundle between a host and stopwatch_ctrl.
interface stopwatch_ctrl_if;

  logic                              start;
  logic                              stop;
  logic                              clear;
  logic                              cfg_we;
  logic [stopwatch_pkg::DIV_W-1:0]   cfg_div;
  logic [stopwatch_pkg::TIME_W-1:0]  cfg_alarm_min;
  logic [stopwatch_pkg::TIME_W-1:0]  cfg_alarm_sec;
  logic                              cfg_alarm_en;
  logic                              alarm_ack;
  logic [stopwatch_pkg::TIME_W-1:0]  second;
  logic [stopwatch_pkg::TIME_W-1:0]  minute;
  logic                              running;
  logic                              done;
  logic                              alarm;

  modport master (
    output start, stop, clear, cfg_we, cfg_div, cfg_alarm_min, cfg_alarm_sec,
           cfg_alarm_en, alarm_ack,
    input  second, minute, running, done, alarm
  );

  modport slave (
    input  start, stop, clear, cfg_we, cfg_div, cfg_alarm_min, cfg_alarm_sec,
           cfg_alarm_en, alarm_ack,
    output second, minute, running, done, alarm
  );

endinterface

// File: rtl/stopwatch_ctrl_mmss_counter.sv
// Minute/second datapath: synchronous clear, increment on inc_i, saturates at
// 59:59. next_o is the value an increment would produce this cycle.
module mmss_counter
  import stopwatch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  input  logic              clr_i,
  output logic [TIME_W-1:0] sec_o,
  output logic [TIME_W-1:0] min_o,
  output mmss_t             next_o,
  output logic              terminal_o
);

  logic [TIME_W-1:0] sec_q, sec_d;
  logic [TIME_W-1:0] min_q, min_d;

  assign terminal_o = (sec_q == SEC_MAX) && (min_q == MIN_MAX);

  // Saturating mm:ss increment, independent of inc_i/clr_i.
  always_comb begin
    next_o.sec = sec_q;
    next_o.min = min_q;
    if (terminal_o) begin
      next_o.sec = sec_q;
      next_o.min = min_q;
    end else if (sec_q == SEC_MAX) begin
      next_o.sec = 6'd0;
      next_o.min = min_q + 6'd1;
    end else begin
      next_o.sec = sec_q + 6'd1;
      next_o.min = min_q;
    end
  end

  // Clear outranks increment.
  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    if (clr_i) begin
      sec_d = 6'd0;
      min_d = 6'd0;
    end else if (inc_i) begin
      sec_d = next_o.sec;
      min_d = next_o.min;
    end else begin
      sec_d = sec_q;
      min_d = min_q;
    end
  end

  // Time registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q <= 6'd0;
      min_q <= 6'd0;
    end else begin
      sec_q <= sec_d;
      min_q <= min_d;
    end
  end

  assign sec_o = sec_q;
  assign min_o = min_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: command FSM, tick prescaler, IDLE-only configuration
// registers and the sticky alarm, wrapped around the mm:ss counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  stopwatch_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  presc_q, presc_d;
  logic [DIV_W-1:0]  div_q, div_d;
  mmss_t             alarm_t_q, alarm_t_d;
  logic              alarm_en_q, alarm_en_d;
  logic              alarm_q, alarm_d;
  logic              running_q, running_d;
  logic              done_q, done_d;

  logic              tick_s;
  logic              last_tick_s;
  logic              cnt_inc_s;
  logic              cnt_clr_s;
  logic              alarm_set_s;
  logic              terminal_s;
  logic [TIME_W-1:0] sec_s, min_s;
  mmss_t             next_s;

  mmss_counter u_mmss (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (cnt_inc_s),
    .clr_i      (cnt_clr_s),
    .sec_o      (sec_s),
    .min_o      (min_s),
    .next_o     (next_s),
    .terminal_o (terminal_s)
  );

  assign tick_s      = (state_q == RUN) && (presc_q == div_q);
  assign last_tick_s = terminal_s ||
                       ((next_s.min == MIN_MAX) && (next_s.sec == SEC_MAX));

  // FSM, prescaler and counter strobes; clear beats stop beats start, so a
  // stop in the same cycle as start holds off the start even where stop
  // itself has nothing to do.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_inc_s = 1'b0;
    cnt_clr_s = 1'b0;
    if (bus.clear) begin
      state_d   = IDLE;
      presc_d   = 8'd0;
      cnt_clr_s = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.stop) begin
            state_d = IDLE;
          end else if (bus.start) begin
            state_d = RUN;
            presc_d = 8'd0;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_d = PAUSE;
          end else if (tick_s) begin
            presc_d   = 8'd0;
            cnt_inc_s = 1'b1;
            state_d   = last_tick_s ? DONE : RUN;
          end else begin
            presc_d = presc_q + 8'd1;
          end
        end
        PAUSE: begin
          if (bus.stop) begin
            state_d = PAUSE;
          end else if (bus.start) begin
            state_d = RUN;
          end else begin
            state_d = PAUSE;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
          presc_d = 8'd0;
        end
      endcase
    end
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  // Sticky alarm and configuration capture (accepted only while IDLE).
  always_comb begin
    alarm_set_s = cnt_inc_s && alarm_en_q && time_valid(alarm_t_q) &&
                  (next_s == alarm_t_q);
    if (bus.clear) begin
      alarm_d = 1'b0;
    end else if (alarm_set_s) begin
      alarm_d = 1'b1;
    end else if (bus.alarm_ack) begin
      alarm_d = 1'b0;
    end else begin
      alarm_d = alarm_q;
    end

    div_d      = div_q;
    alarm_t_d  = alarm_t_q;
    alarm_en_d = alarm_en_q;
    if ((state_q == IDLE) && bus.cfg_we) begin
      div_d         = bus.cfg_div;
      alarm_t_d.min = bus.cfg_alarm_min;
      alarm_t_d.sec = bus.cfg_alarm_sec;
      alarm_en_d    = bus.cfg_alarm_en;
    end else begin
      div_d      = div_q;
      alarm_t_d  = alarm_t_q;
      alarm_en_d = alarm_en_q;
    end
  end

  // Control, configuration and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      presc_q    <= 8'd0;
      div_q      <= 8'd0;
      alarm_t_q  <= 12'd0;
      alarm_en_q <= 1'b0;
      alarm_q    <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      div_q      <= div_d;
      alarm_t_q  <= alarm_t_d;
      alarm_en_q <= alarm_en_d;
      alarm_q    <= alarm_d;
      running_q  <= running_d;
      done_q     <= done_d;
    end
  end

  assign bus.second  = sec_s;
  assign bus.minute  = min_s;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.alarm   = alarm_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: command table, directed corner sequences and
// random commands checked every cycle against a seconds-count model.
module tb_stopwatch_ctrl;

  logic clk;
  logic rst_n;
  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: elapsed seconds as one integer, state as a tb-local enum.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_e;
  mst_e m_st;
  int   m_t, m_p, m_div, m_amin, m_asec;
  bit   m_aen, m_alarm;

  typedef struct {
    bit         start, stop, clear;
    logic [5:0] exp_sec, exp_min;
    bit         exp_run, exp_done;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_st = M_IDLE; m_t = 0; m_p = 0; m_div = 0;
    m_amin = 0; m_asec = 0; m_aen = 1'b0; m_alarm = 1'b0;
  endfunction

  function automatic void model_step(bit st, bit sp, bit cl, bit we, bit ack);
    mst_e old = m_st;
    bit   set = 1'b0;
    if (cl) begin
      m_st = M_IDLE; m_t = 0; m_p = 0; m_alarm = 1'b0;
    end else begin
      case (old)
        M_IDLE:  if (!sp && st) begin m_st = M_RUN; m_p = 0; end
        M_RUN: begin
          if (sp) m_st = M_PAUSE;
          else if (m_p == m_div) begin
            m_p = 0;
            m_t = m_t + 1;
            if (m_aen && m_amin < 60 && m_asec < 60 && m_t == m_amin * 60 + m_asec) set = 1'b1;
            if (m_t == 3599) m_st = M_DONE;
          end else m_p = m_p + 1;
        end
        M_PAUSE: if (!sp && st) m_st = M_RUN;
        default: ;
      endcase
      if (set) m_alarm = 1'b1;
      else if (ack) m_alarm = 1'b0;
    end
    if (old == M_IDLE && we) begin
      m_div  = int'(sw_if.cfg_div);
      m_amin = int'(sw_if.cfg_alarm_min);
      m_asec = int'(sw_if.cfg_alarm_sec);
      m_aen  = sw_if.cfg_alarm_en;
    end
  endfunction

  task automatic set_cfg(input logic [7:0] dv, input logic [5:0] am, input logic [5:0] as, input bit ae);
    sw_if.cfg_div = dv; sw_if.cfg_alarm_min = am;
    sw_if.cfg_alarm_sec = as; sw_if.cfg_alarm_en = ae;
  endtask

  // One clock: drive, advance model, sample 1 ns after the edge, compare.
  task automatic cyc(input bit st, input bit sp, input bit cl, input bit we, input bit ack);
    logic [14:0] exp_v;
    sw_if.start = st; sw_if.stop = sp; sw_if.clear = cl;
    sw_if.cfg_we = we; sw_if.alarm_ack = ack;
    model_step(st, sp, cl, we, ack);
    @(posedge clk);
    #1;
    exp_v = {6'(m_t / 60), 6'(m_t % 60), m_st == M_RUN, m_st == M_DONE, m_alarm};
    chk("model", {sw_if.minute, sw_if.second, sw_if.running, sw_if.done, sw_if.alarm}, exp_v);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cfg_cycle(input logic [7:0] dv, input logic [5:0] am, input logic [5:0] as, input bit ae);
    set_cfg(dv, am, as, ae);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 6'd1, 6'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 6'd2, 6'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 6'd2, 6'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 6'd2, 6'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 6'd2, 6'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 6'd3, 6'd0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 6'd3, 6'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 6'd3, 6'd0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 6'd1, 6'd0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    sw_if.start = 1'b0; sw_if.stop = 1'b0; sw_if.clear = 1'b0;
    sw_if.cfg_we = 1'b0; sw_if.alarm_ack = 1'b0;
    set_cfg(8'd0, 6'd0, 6'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_second",  32'(sw_if.second),  32'd0);
    chk("rst_minute",  32'(sw_if.minute),  32'd0);
    chk("rst_running", 32'(sw_if.running), 32'd0);
    chk("rst_done",    32'(sw_if.done),    32'd0);
    chk("rst_alarm",   32'(sw_if.alarm),   32'd0);
    rst_n = 1'b1;

    // Command table at div=0.
    cfg_cycle(8'd0, 6'd0, 6'd0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].start, tbl[i].stop, tbl[i].clear, 1'b0, 1'b0);
      chk($sformatf("tbl%0d", i), {sw_if.minute, sw_if.second, sw_if.running, sw_if.done},
          {tbl[i].exp_min, tbl[i].exp_sec, tbl[i].exp_run, tbl[i].exp_done});
    end

    // Prescaler latency with div=3.
    cfg_cycle(8'd3, 6'd0, 6'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("div3_k0", 32'(sw_if.second), 32'd0);
    idle(3); chk("div3_k3", 32'(sw_if.second), 32'd0);
    idle(1); chk("div3_k4", 32'(sw_if.second), 32'd1);
    idle(3); chk("div3_k7", 32'(sw_if.second), 32'd1);
    idle(1); chk("div3_k8", 32'(sw_if.second), 32'd2);

    // div=0: one increment per cycle, minute carry at 60.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg_cycle(8'd0, 6'd0, 6'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);  chk("div0_first", 32'(sw_if.second), 32'd1);
    idle(59); chk("div0_60", {sw_if.minute, sw_if.second, sw_if.running}, {6'd1, 6'd0, 1'b1});

    // start+stop+clear together while running at 00:10.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(10); chk("pre_all_cmd", 32'(sw_if.second), 32'd10);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("all_cmd", {sw_if.minute, sw_if.second, sw_if.running, sw_if.done}, {6'd0, 6'd0, 1'b0, 1'b0});

    // Pause at 00:07, config write ignored while paused, resume.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(7);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_cfg(8'd5, 6'd0, 6'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    set_cfg(8'd0, 6'd0, 6'd0, 1'b0);
    idle(19);
    chk("pause_hold", {sw_if.second, sw_if.running}, {6'd7, 1'b0});
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("resume", {sw_if.second, sw_if.running}, {6'd7, 1'b1});
    idle(1); chk("resume_div", 32'(sw_if.second), 32'd8);

    // Full run to 59:59.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3598);
    chk("end_minus1", {sw_if.minute, sw_if.second, sw_if.running, sw_if.done}, {6'd59, 6'd58, 1'b1, 1'b0});
    idle(1);
    chk("end_done", {sw_if.minute, sw_if.second, sw_if.running, sw_if.done}, {6'd59, 6'd59, 1'b0, 1'b1});
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("done_hold", {sw_if.minute, sw_if.second, sw_if.done}, {6'd59, 6'd59, 1'b1});

    // Alarm at 00:05, sticky until ack.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg_cycle(8'd0, 6'd0, 6'd5, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4); chk("alarm_before", 32'(sw_if.alarm), 32'd0);
    idle(1); chk("alarm_set", {sw_if.second, sw_if.alarm}, {6'd5, 1'b1});
    idle(3); chk("alarm_sticky", 32'(sw_if.alarm), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("alarm_ack", 32'(sw_if.alarm), 32'd0);

    // Set coincident with ack keeps the flag.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("alarm_set_ack", 32'(sw_if.alarm), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("alarm_ack2", 32'(sw_if.alarm), 32'd0);

    // Out-of-range alarm second never fires.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg_cycle(8'd0, 6'd0, 6'd60, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(70);
    chk("alarm_invalid", 32'(sw_if.alarm), 32'd0);

    // Asynchronous reset mid-count also clears the configuration.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg_cycle(8'd3, 6'd0, 6'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_time", {sw_if.minute, sw_if.second, sw_if.running}, {6'd0, 6'd0, 1'b0});
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("arst_div", 32'(sw_if.second), 32'd1);

    // Random commands against the model.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        set_cfg(8'($urandom_range(0, 3)), 6'($urandom_range(0, 1)),
                6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: start  in  1  single-cycle command: begin or resume counting.
REQ-004 SHALL: stop  in  1  single-cycle command: pause counting.
REQ-005 SHALL: clear  in  1  single-cycle command: return to IDLE at 00:00.
REQ-006 SHALL: cfg_we  in  1  configuration write strobe.
REQ-007 SHALL: cfg_div  in  8  prescaler value; one tick every cfg_div+1 clk cycles.
REQ-008 SHALL: cfg_alarm_min, cfg_alarm_sec  in  6 each  alarm compare time.
REQ-009 SHALL: cfg_alarm_en  in  1  alarm enable.
REQ-010 SHALL: alarm_ack  in  1  clears the sticky alarm flag.
REQ-011 SHALL: second, minute  out  6 each  current time, registered, range 0..59.
REQ-012 SHALL: running  out  1  high only in state RUN.
REQ-013 SHALL: done  out  1  high only in state DONE.
REQ-014 SHALL: alarm  out  1  sticky alarm flag, registered.

Function
REQ-015 SHALL: FSM states IDLE, RUN, PAUSE, DONE; command priority clear > stop > start within one cycle.
REQ-016 SHALL: IDLE: start -> RUN with prescaler at 0; stop ignored.
REQ-017 SHALL: RUN: clear -> IDLE; stop -> PAUSE (time and prescaler held); tick at 59:59 -> DONE.
REQ-018 SHALL: PAUSE: start -> RUN with prescaler value preserved; clear -> IDLE.
REQ-019 SHALL: DONE: time held at 59:59; start and stop ignored; clear -> IDLE.
REQ-020 SHALL: clear in any state forces second=0, minute=0, prescaler=0, alarm=0 on the next edge.
REQ-021 SHALL: in RUN the prescaler counts 0..div and wraps; tick is asserted in the cycle where prescaler==div.
REQ-022 SHALL: latency: start sampled at edge k -> first time increment at edge k+div+1; div=0 gives one increment per cycle.
REQ-023 SHALL: on tick, second increments; at 59 it wraps to 0 and minute increments in the same edge.
REQ-024 SHALL: on tick at 59:59, time stays 59:59 and state enters DONE; no wrap to 00:00.
REQ-025 SHALL: stop coincident with a tick suppresses that tick (time unchanged).
REQ-026 SHALL: cfg_we latches div, alarm time and alarm enable only in IDLE; ignored in other states.
REQ-027 SHALL: alarm sets on the edge where a tick makes time equal the alarm time and alarm_en=1.
REQ-028 SHALL: alarm stays set until alarm_ack or clear; a simultaneous set and alarm_ack leaves alarm=1.
REQ-029 SHALL: an alarm time >59 never matches and never sets alarm.

Reset
REQ-030 SHALL: rst_n low forces state=IDLE, second=0, minute=0, prescaler=0, alarm=0, running=0, done=0.
REQ-031 SHALL: rst_n low forces div=0, alarm time=00:00, alarm_en=0.
REQ-032 SHALL: reset asserted mid-count takes effect immediately and asynchronously; no commands are accepted until the first edge after release.

Structure
REQ-033 SHALL: package stopwatch_pkg holds the state enum, SEC_MAX=59, MIN_MAX=59, TIME_W=6 and DIV_W=8.
REQ-034 SHALL: sub-module mmss_counter implements the second/minute datapath: inputs inc and clr, output terminal (59:59), saturating at terminal.
REQ-035 SHALL: stopwatch_ctrl owns the FSM, prescaler, config registers and alarm logic.

Verification
REQ-036 SHALL: cfg div=0, start -> second=1 one edge later; after 60 ticks time=01:00, running=1.
REQ-037 SHALL: cfg div=3, start at edge k -> second=1 at edge k+4 and second=2 at edge k+8.
REQ-038 SHALL: run div=0 for 3599 ticks -> time=59:59 and done=1 on the same edge; further starts leave 59:59.
REQ-039 SHALL: alarm 00:05, en=1, div=0 -> alarm=1 on the edge second becomes 5; stays 1 until alarm_ack.
REQ-040 SHALL: start+stop+clear in one cycle during RUN at 00:10 -> IDLE, 00:00, running=0.
REQ-041 SHALL: stop at 00:07, idle 20 cycles, start -> counting resumes from 00:07; cfg_we in PAUSE leaves div unchanged.
